// File: rtl/shift_normalizer.sv
// Iterative leading-zero / redundant-sign normalizer: shifts the captured operand
// left by one bit per cycle and reports the shift count with a valid/ready handshake.
module shift_normalizer #(
  parameter int Width = 32,
  parameter int CntW  = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [Width-1:0] dataIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] dataOut,
  output logic [CntW-1:0]  out_count,
  output logic             out_zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CntW-1:0] CNT_FULL       = CntW'(Width);
  localparam logic [CntW-1:0] CNT_SIGNED_MAX = CntW'(Width - 1);

  logic [1:0]       state_q, state_d;
  logic [Width-1:0] data_q, data_d;
  logic             mode_q, mode_d;
  logic             zero_q, zero_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] data_out_q, data_out_d;
  logic [CntW-1:0]  out_count_q, out_count_d;
  logic             out_zero_q, out_zero_d;
  logic             shift_en;

  // Signed mode stops one short of the full width so a sign bit always remains.
  assign shift_en = mode_q ? ((data_q[Width-1] == data_q[Width-2]) && (cnt_q < CNT_SIGNED_MAX))
                           : !data_q[Width-1];

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mode_d      = mode_q;
    zero_d      = zero_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    out_count_d = out_count_q;
    out_zero_d  = out_zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = dataIn;
          mode_d = in_mode;
          zero_d = (dataIn == '0);
          cnt_d  = '0;
          if (!in_mode && (dataIn == '0)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            data_out_d  = '0;
            out_count_d = CNT_FULL;
            out_zero_d  = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (shift_en) begin
          data_d = {data_q[Width-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
        end else begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          data_out_d  = data_q;
          out_count_d = cnt_q;
          out_zero_d  = zero_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      mode_q      <= 1'b0;
      zero_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      zero_q      <= zero_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      out_count_q <= out_count_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign dataOut   = data_out_q;
  assign out_count = out_count_q;
  assign out_zero  = out_zero_q;

endmodule
